// File: rtl/hazard_tracker.sv
// hazard_tracker
// Decode-stage read-after-write hazard tracker for the 16-bit pipelined core.
// Keeps a shift register of in-flight destination writes (youngest at entry 0,
// writeback at entry DEPTH-1), raises the bubble-insert stall, produces the
// optional forwarding selects, drives the registered writeback select/enable
// and counts stall cycles with saturation.
module hazard_tracker #(
  parameter int REG_W        = 3,
  parameter int DEPTH        = 3,
  parameter int FWD_EN       = 0,
  parameter int WB_BYPASS    = 1,
  parameter int FLUSH_STAGES = 2,
  localparam int FWD_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs_sel,
  input  logic [REG_W-1:0] rt_sel,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic [REG_W-1:0] rd_sel,
  input  logic             rd_wr,
  input  logic             rd_load,
  input  logic             hold,
  input  logic             flush,
  output logic             stall,
  output logic [FWD_W-1:0] fwd_rs,
  output logic [FWD_W-1:0] fwd_rt,
  output logic [REG_W-1:0] wb_sel,
  output logic             wb_en,
  output logic [15:0]      stall_cnt
);

  // Highest entry index that is still compared against the decode sources.
  // With a bypassing register file the writeback entry never causes a hazard.
  localparam int CMP_HI = DEPTH - 1 - WB_BYPASS;

  logic [DEPTH-1:0] r_v;
  logic [REG_W-1:0] r_rd [DEPTH];
  logic [DEPTH-1:0] r_ld;
  logic [15:0]      r_stall_cnt;

  logic [DEPTH-1:0] w_match_rs;
  logic [DEPTH-1:0] w_match_rt;
  logic             w_stall;
  logic [FWD_W-1:0] w_fwd_rs;
  logic [FWD_W-1:0] w_fwd_rt;

  // Per-entry source/destination match, limited to the compare range.
  always_comb begin
    w_match_rs = {DEPTH{1'b0}};
    w_match_rt = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (i <= CMP_HI) begin
        w_match_rs[i] = rs_used & id_valid & r_v[i] & (r_rd[i] == rs_sel);
        w_match_rt[i] = rt_used & id_valid & r_v[i] & (r_rd[i] == rt_sel);
      end else begin
        w_match_rs[i] = 1'b0;
        w_match_rt[i] = 1'b0;
      end
    end
  end

  // Stall decision: any hazard without forwarding, only load-use with it.
  always_comb begin
    w_stall = 1'b0;
    if (FWD_EN != 0) begin
      w_stall = (w_match_rs[0] | w_match_rt[0]) & r_ld[0];
    end else begin
      w_stall = (|w_match_rs) | (|w_match_rt);
    end
  end

  // Forward select: youngest matching producer wins; zero while stalling.
  always_comb begin
    w_fwd_rs = {FWD_W{1'b0}};
    w_fwd_rt = {FWD_W{1'b0}};
    if ((FWD_EN != 0) && !w_stall) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        w_fwd_rs = w_match_rs[i] ? FWD_W'(i + 1) : w_fwd_rs;
        w_fwd_rt = w_match_rt[i] ? FWD_W'(i + 1) : w_fwd_rt;
      end
    end else begin
      w_fwd_rs = {FWD_W{1'b0}};
      w_fwd_rt = {FWD_W{1'b0}};
    end
  end

  // In-flight write shift register; a stall or flush loads a bubble into
  // entry 0 and a flush also squashes the youngest shifted entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_v[i]  <= 1'b0;
        r_rd[i] <= {REG_W{1'b0}};
        r_ld[i] <= 1'b0;
      end
    end else if (!hold) begin
      r_v[0]  <= id_valid & rd_wr & ~w_stall & ~flush;
      r_rd[0] <= rd_sel;
      r_ld[0] <= rd_load;
      for (int i = 1; i < DEPTH; i++) begin
        if (flush && (i < FLUSH_STAGES)) begin
          r_v[i]  <= 1'b0;
          r_rd[i] <= {REG_W{1'b0}};
          r_ld[i] <= 1'b0;
        end else begin
          r_v[i]  <= r_v[i-1];
          r_rd[i] <= r_rd[i-1];
          r_ld[i] <= r_ld[i-1];
        end
      end
    end
  end

  // Saturating count of cycles in which a bubble was actually inserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (!hold && w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall     = w_stall;
  assign fwd_rs    = w_fwd_rs;
  assign fwd_rt    = w_fwd_rt;
  assign wb_sel    = r_rd[DEPTH-1];
  assign wb_en     = r_v[DEPTH-1];
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker. Four instances share one stimulus:
// u0 default, u1 without writeback bypass, u2 with forwarding, u3 deep
// (DEPTH=32) used to drive the stall counter into saturation.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] rs_sel, rt_sel, rd_sel;
  logic       rs_used, rt_used, rd_wr, rd_load, hold, flush;

  logic       stall_0, stall_1, stall_2, stall_3;
  logic [1:0] fwd_rs_0, fwd_rt_0, fwd_rs_1, fwd_rt_1, fwd_rs_2, fwd_rt_2;
  logic [5:0] fwd_rs_3, fwd_rt_3;
  logic [2:0] wb_sel_0, wb_sel_1, wb_sel_2, wb_sel_3;
  logic       wb_en_0, wb_en_1, wb_en_2, wb_en_3;
  logic [15:0] cnt_0, cnt_1, cnt_2, cnt_3;

  typedef struct {
    int    inst;
    int    stall;
    int    frs;
    int    frt;
    int    wben;
    int    wbsel;   // -1: select not compared (no writeback expected)
    int    cnt;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sat_exp;

  always #5 clk = ~clk;

  hazard_tracker #(.DEPTH(3), .FWD_EN(0), .WB_BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs_sel(rs_sel), .rt_sel(rt_sel),
    .rs_used(rs_used), .rt_used(rt_used), .rd_sel(rd_sel), .rd_wr(rd_wr),
    .rd_load(rd_load), .hold(hold), .flush(flush), .stall(stall_0),
    .fwd_rs(fwd_rs_0), .fwd_rt(fwd_rt_0), .wb_sel(wb_sel_0), .wb_en(wb_en_0),
    .stall_cnt(cnt_0));

  hazard_tracker #(.DEPTH(3), .FWD_EN(0), .WB_BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs_sel(rs_sel), .rt_sel(rt_sel),
    .rs_used(rs_used), .rt_used(rt_used), .rd_sel(rd_sel), .rd_wr(rd_wr),
    .rd_load(rd_load), .hold(hold), .flush(flush), .stall(stall_1),
    .fwd_rs(fwd_rs_1), .fwd_rt(fwd_rt_1), .wb_sel(wb_sel_1), .wb_en(wb_en_1),
    .stall_cnt(cnt_1));

  hazard_tracker #(.DEPTH(3), .FWD_EN(1), .WB_BYPASS(1)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs_sel(rs_sel), .rt_sel(rt_sel),
    .rs_used(rs_used), .rt_used(rt_used), .rd_sel(rd_sel), .rd_wr(rd_wr),
    .rd_load(rd_load), .hold(hold), .flush(flush), .stall(stall_2),
    .fwd_rs(fwd_rs_2), .fwd_rt(fwd_rt_2), .wb_sel(wb_sel_2), .wb_en(wb_en_2),
    .stall_cnt(cnt_2));

  hazard_tracker #(.DEPTH(32), .FWD_EN(0), .WB_BYPASS(0)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs_sel(rs_sel), .rt_sel(rt_sel),
    .rs_used(rs_used), .rt_used(rt_used), .rd_sel(rd_sel), .rd_wr(rd_wr),
    .rd_load(rd_load), .hold(hold), .flush(flush), .stall(stall_3),
    .fwd_rs(fwd_rs_3), .fwd_rt(fwd_rt_3), .wb_sel(wb_sel_3), .wb_en(wb_en_3),
    .stall_cnt(cnt_3));

  task automatic check_val(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic ex(input int inst, input int st, input int frs, input int frt,
                    input int we, input int ws, input int cnt, input string tag);
    exp_t e;
    e.inst = inst; e.stall = st; e.frs = frs; e.frt = frt;
    e.wben = we; e.wbsel = ws; e.cnt = cnt; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Drives one decode slot just after the rising edge; control inputs default
  // to run mode and may be overridden by the caller in the same time step.
  task automatic cyc(input logic v, input logic [2:0] rs, input logic rsu,
                     input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                     input logic wr, input logic ld);
    @(posedge clk);
    #1;
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    id_valid = v; rs_sel = rs; rs_used = rsu; rt_sel = rt; rt_used = rtu;
    rd_sel = rd; rd_wr = wr; rd_load = ld;
  endtask

  task automatic nop();                  cyc(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); endtask
  task automatic wr(input logic [2:0] r, input logic ld); cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, r, 1'b1, ld); endtask
  task automatic rdrs(input logic [2:0] r);   cyc(1'b1, r, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); endtask
  task automatic rdrt(input logic [2:0] r);   cyc(1'b1, 3'd0, 1'b0, r, 1'b1, 3'd0, 1'b0, 1'b0); endtask
  task automatic rdboth(input logic [2:0] r); cyc(1'b1, r, 1'b1, r, 1'b1, 3'd0, 1'b0, 1'b0); endtask
  task automatic rst_cyc();              nop(); rst = 1'b0; endtask

  // Scoreboard consumer: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    int ost, ofrs, ofrt, owe, ows, ocnt;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.inst)
        0: begin ost = int'(stall_0); ofrs = int'(fwd_rs_0); ofrt = int'(fwd_rt_0);
                 owe = int'(wb_en_0); ows = int'(wb_sel_0); ocnt = int'(cnt_0); end
        1: begin ost = int'(stall_1); ofrs = int'(fwd_rs_1); ofrt = int'(fwd_rt_1);
                 owe = int'(wb_en_1); ows = int'(wb_sel_1); ocnt = int'(cnt_1); end
        2: begin ost = int'(stall_2); ofrs = int'(fwd_rs_2); ofrt = int'(fwd_rt_2);
                 owe = int'(wb_en_2); ows = int'(wb_sel_2); ocnt = int'(cnt_2); end
        3: begin ost = int'(stall_3); ofrs = int'(fwd_rs_3); ofrt = int'(fwd_rt_3);
                 owe = int'(wb_en_3); ows = int'(wb_sel_3); ocnt = int'(cnt_3); end
        default: begin ost = -1; ofrs = -1; ofrt = -1; owe = -1; ows = -1; ocnt = -1; end
      endcase
      check_val({e.tag, ".stall"}, ost, e.stall);
      check_val({e.tag, ".fwd_rs"}, ofrs, e.frs);
      check_val({e.tag, ".fwd_rt"}, ofrt, e.frt);
      check_val({e.tag, ".wb_en"}, owe, e.wben);
      if (e.wbsel >= 0) check_val({e.tag, ".wb_sel"}, ows, e.wbsel);
      check_val({e.tag, ".stall_cnt"}, ocnt, e.cnt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; id_valid = 1'b0; rs_sel = 3'd0; rt_sel = 3'd0; rd_sel = 3'd0;
    rs_used = 1'b0; rt_used = 1'b0; rd_wr = 1'b0; rd_load = 1'b0;
    hold = 1'b0; flush = 1'b0;

    // Reset held with random inputs: everything quiet.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      id_valid = 1'($urandom); rs_sel = 3'($urandom); rt_sel = 3'($urandom);
      rs_used = 1'($urandom); rt_used = 1'($urandom); rd_sel = 3'($urandom);
      rd_wr = 1'($urandom); rd_load = 1'($urandom); hold = 1'($urandom);
      flush = 1'($urandom);
      for (int n = 0; n < 4; n++) ex(n, 0, 0, 0, 0, 0, 0, "rst");
    end

    // Writeback latency after release: write r3, wb 3 cycles later.
    wr(3'd3, 1'b0); ex(0, 0, 0, 0, 0, -1, 0, "lat_iss");
    nop();          ex(0, 0, 0, 0, 0, -1, 0, "lat_d1");
    nop();          ex(0, 0, 0, 0, 0, -1, 0, "lat_d2");
    nop();          ex(0, 0, 0, 0, 1, 3, 0, "lat_wb");
    nop();          ex(0, 0, 0, 0, 0, -1, 0, "lat_done");

    // No forwarding: 2 stalls with bypass (u0), 3 without (u1).
    rst_cyc();      ex(0, 0, 0, 0, 0, 0, 0, "s_rst"); ex(1, 0, 0, 0, 0, 0, 0, "s_rst");
    wr(3'd2, 1'b0); ex(0, 0, 0, 0, 0, -1, 0, "s0_iss"); ex(1, 0, 0, 0, 0, -1, 0, "s1_iss");
    rdrs(3'd2);     ex(0, 1, 0, 0, 0, -1, 0, "s0_st1"); ex(1, 1, 0, 0, 0, -1, 0, "s1_st1");
    rdrs(3'd2);     ex(0, 1, 0, 0, 0, -1, 1, "s0_st2"); ex(1, 1, 0, 0, 0, -1, 1, "s1_st2");
    rdrs(3'd2);     ex(0, 0, 0, 0, 1, 2, 2, "s0_go");   ex(1, 1, 0, 0, 1, 2, 2, "s1_st3");
    rdrs(3'd2);     ex(0, 0, 0, 0, 0, -1, 2, "s0_after"); ex(1, 0, 0, 0, 0, -1, 3, "s1_go");
    nop();          ex(0, 0, 0, 0, 0, -1, 2, "s0_end"); ex(1, 0, 0, 0, 0, -1, 3, "s1_end");

    // Forwarding (u2): ALU forward, youngest producer, older entry, load-use.
    rst_cyc();      ex(2, 0, 0, 0, 0, 0, 0, "f_rst");
    wr(3'd4, 1'b0); ex(2, 0, 0, 0, 0, -1, 0, "f_iss");
    rdboth(3'd4);   ex(2, 0, 1, 1, 0, -1, 0, "f_fwd1");
    wr(3'd4, 1'b0); ex(2, 0, 0, 0, 0, -1, 0, "f_iss2");
    wr(3'd4, 1'b0); ex(2, 0, 0, 0, 1, 4, 0, "f_iss3");
    rdboth(3'd4);   ex(2, 0, 1, 1, 0, -1, 0, "f_young");
    rdrs(3'd4);     ex(2, 0, 2, 0, 1, 4, 0, "f_fwd2");
    nop();          ex(2, 0, 0, 0, 1, 4, 0, "f_wb3");
    nop();          ex(2, 0, 0, 0, 0, -1, 0, "f_idle");
    wr(3'd5, 1'b1); ex(2, 0, 0, 0, 0, -1, 0, "lu_iss");
    rdrt(3'd5);     ex(2, 1, 0, 0, 0, -1, 0, "lu_stall");
    rdrt(3'd5);     ex(2, 0, 0, 2, 0, -1, 1, "lu_fwd");
    nop();          ex(2, 0, 0, 0, 1, 5, 1, "lu_wb");

    // Flush (u0): r3 and the flushed instruction never write back.
    rst_cyc();      ex(0, 0, 0, 0, 0, 0, 0, "fl_rst");
    wr(3'd1, 1'b0); ex(0, 0, 0, 0, 0, -1, 0, "fl_w1");
    wr(3'd2, 1'b0); ex(0, 0, 0, 0, 0, -1, 0, "fl_w2");
    wr(3'd3, 1'b0); ex(0, 0, 0, 0, 0, -1, 0, "fl_w3");
    wr(3'd6, 1'b0); flush = 1'b1; ex(0, 0, 0, 0, 1, 1, 0, "fl_r1");
    nop();          ex(0, 0, 0, 0, 1, 2, 0, "fl_r2");
    nop();          ex(0, 0, 0, 0, 0, -1, 0, "fl_r3sq");
    nop();          ex(0, 0, 0, 0, 0, -1, 0, "fl_newsq");
    nop();          ex(0, 0, 0, 0, 0, -1, 0, "fl_end");

    // Hold during a stall (with a flush under hold), then mid-stall reset.
    rst_cyc();      ex(0, 0, 0, 0, 0, 0, 0, "h_rst");
    wr(3'd2, 1'b0); ex(0, 0, 0, 0, 0, -1, 0, "h_iss");
    rdrs(3'd2);     ex(0, 1, 0, 0, 0, -1, 0, "h_st");
    for (int k = 0; k < 5; k++) begin
      rdrs(3'd2);
      hold = 1'b1;
      if (k == 2) flush = 1'b1;
      ex(0, 1, 0, 0, 0, -1, 1, "h_frz");
    end
    rdrs(3'd2);     ex(0, 1, 0, 0, 0, -1, 1, "h_rel");
    rdrs(3'd2);     ex(0, 0, 0, 0, 1, 2, 2, "h_go");
    wr(3'd3, 1'b0); ex(0, 0, 0, 0, 0, -1, 2, "m_iss");
    rdrs(3'd3);     ex(0, 1, 0, 0, 0, -1, 2, "m_st");
    rdrs(3'd3); rst = 1'b0; ex(0, 0, 0, 0, 0, 0, 0, "m_rst");
    nop();          ex(0, 0, 0, 0, 0, 0, 0, "m_after");

    // Saturation (u3): one producer gives 32 stalls in a 32-deep window.
    rst_cyc();      ex(3, 0, 0, 0, 0, 0, 0, "sat_rst");
    sat_exp = 0;
    while (sat_exp < 65534) begin
      wr(3'd7, 1'b0);
      for (int k = 0; k < 32 && sat_exp < 65534; k++) begin
        rdrs(3'd7);
        sat_exp++;
      end
    end
    rdrs(3'd7);     ex(3, 1, 0, 0, 0, -1, 65534, "sat_fffe");
    rdrs(3'd7);     ex(3, 1, 0, 0, 1, 7, 65535, "sat_ffff");
    wr(3'd7, 1'b0); ex(3, 0, 0, 0, 0, -1, 65535, "sat_iss");
    rdrs(3'd7);     ex(3, 1, 0, 0, 0, -1, 65535, "sat_hold");
    nop();          ex(3, 0, 0, 0, 0, -1, 65535, "sat_end");

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Parametrised register-hazard tracker for the decode stage of the 16-bit pipelined core. It holds a shift register of in-flight destination writes and detects read-after-write hazards for the two source operands of the instruction in decode. It generates the stall (bubble-insert) signal, optional forwarding selects, and the delayed writeback register select and enable. It generalises the fixed three-deep RD/RegWrt flop chain and stall logic with configurable depth, a forwarding mode, load-use detection, flush and hold handling, and a stall counter.

## Interface
- REG_W, 3: register index width (2^REG_W architectural registers)
- DEPTH, 3: pipeline stages tracked between decode and writeback (≥2)
- FWD_EN, 0: 0 = stall on any hazard; 1 = forward where possible, stall only on load-use
- WB_BYPASS, 1: 1 = register file bypasses same-cycle writes, so the writeback entry (DEPTH-1) is excluded from hazard checks
- FLUSH_STAGES, 2: number of youngest entries (0..FLUSH_STAGES-1) invalidated by flush

- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low
- id_valid  in  1  decode holds a real instruction
- rs_sel / rt_sel  in  REG_W  source register indices
- rs_used / rt_used  in  1  source is actually read
- rd_sel  in  REG_W  destination index
- rd_wr  in  1  instruction writes rd
- rd_load  in  1  rd value comes from memory
- hold  in  1  downstream freeze; all state holds
- flush  in  1  squash younger entries
- stall  out  1  decode must hold its instruction; a bubble is inserted
- fwd_rs / fwd_rt  out  $clog2(DEPTH+1)  0 = register file, k = entry k-1 supplies the value
- wb_sel  out  REG_W  writeback register select (entry DEPTH-1)
- wb_en  out  1  writeback enable (entry DEPTH-1 valid and writing)
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Entry e[i] = {v, rd, ld}, for i = 0..DEPTH-1. e[0] is the instruction just issued to execute; e[DEPTH-1] is in writeback.
- Compare range: i = 0..DEPTH-1-WB_BYPASS.
- match_s[i] = s_used & id_valid & e[i].v & (e[i].rd == s_sel), for s ∈ {rs, rt}.
- FWD_EN=0:
  - stall = any match on rs or rt.
  - fwd_* is always 0.
- FWD_EN=1:
  - stall = (match_rs[0] | match_rt[0]) & e[0].ld.
  - Otherwise, fwd_s = 1 + the lowest i with match_s[i] (the youngest producer wins); 0 if there is no match.
  - When stall=1, fwd_* is 0.
- Shift, per clock edge, when hold=0:
  - e[i] ← e[i-1] for i ≥ 1.
  - e[0] ← {id_valid & rd_wr & ~stall & ~flush, rd_sel, rd_load}.
  - A stall therefore inserts an invalid bubble in e[0].
- flush (hold=0): after the shift, entries 1..FLUSH_STAGES-1 are cleared, and e[0] is invalid (as above). Older entries shift normally.
- hold=1: entries, wb outputs and stall_cnt freeze. Combinational stall/fwd still reflect the current inputs. hold dominates flush.
- stall_cnt increments on each edge where stall=1 & hold=0, and saturates at 16'hFFFF.
- Register index 0 is an ordinary register (no hard-wired zero).

## Timing
- Reset (rst=0, asynchronous): all e[i].v=0, rd=0, ld=0, stall_cnt=0.
- While in reset: stall=0, fwd_rs=fwd_rt=0, wb_en=0, wb_sel=0.
- Release is synchronous to the next clk edge.
- stall and fwd_* are combinational from the inputs and the registered entries, in the same cycle.
- wb_sel/wb_en are registered: an instruction accepted at edge n appears on wb_* after edge n+DEPTH-1, i.e. the writeback latency is DEPTH cycles from issue.
- Simultaneous flush and stall: the bubble is inserted and the flush clears as specified; stall_cnt still counts.
- Reset asserted mid-stall clears all entries immediately; stall drops in the same cycle.

## Test plan
- Reset:
  - Stimulus: rst=0 with random inputs.
  - Required: stall=0, wb_en=0, stall_cnt=0.
  - Then, after release, issue write r3 and no reads: wb_en=1, wb_sel=3 exactly 3 cycles later (DEPTH=3).
- FWD_EN=0, WB_BYPASS=1:
  - Stimulus: write r2, then an instruction reading rs=r2.
  - Required: stall=1 for 2 cycles, then 0; stall_cnt=2.
  - With WB_BYPASS=0 the same sequence gives 3 stall cycles.
- FWD_EN=1:
  - Stimulus: ALU write r4, then read rs=r4, rt=r4.
  - Required: stall=0, fwd_rs=fwd_rt=1.
  - Stimulus: write r4, write r4 again, then read.
  - Required: fwd=1 (youngest producer wins).
- FWD_EN=1, load-use:
  - Stimulus: load r5, then read rt=r5.
  - Required: stall=1 for one cycle, then fwd_rt=2 and stall=0.
- flush:
  - Stimulus: issue writes r1, r2, r3 on consecutive cycles, then flush=1 for one cycle with FLUSH_STAGES=2.
  - Required: r3 and the new instruction are squashed (no wb_en for them); r1 and r2 still write back.
- hold and saturation:
  - Stimulus: hold=1 for 5 cycles during a stall.
  - Required: entries, wb_* and stall_cnt unchanged.
  - Stimulus: preload stall_cnt at 16'hFFFE, then 3 stall cycles.
  - Required: stall_cnt=16'hFFFF.
